// File: rtl/alu_pkg.sv
// Shared ALU control codes and RISC-V opcode constants for the issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SGE     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU control code
// plus operand-select and branch qualifiers.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] ctrl,
    output logic       use_imm,
    output logic       is_branch,
    output logic       br_on_zero,
    output logic       illegal
);

    // Opcode/funct table; anything unlisted stays at the illegal defaults.
    always_comb begin
        ctrl       = ALU_ILLEGAL;
        use_imm    = 1'b0;
        is_branch  = 1'b0;
        br_on_zero = 1'b0;
        illegal    = 1'b1;
        case (opcode)
            OP_R: begin
                case (funct3)
                    F3_ADD:  begin ctrl = funct7_5 ? ALU_SUB : ALU_ADD; illegal = 1'b0; end
                    F3_AND:  begin ctrl = ALU_AND; illegal = 1'b0; end
                    F3_OR:   begin ctrl = ALU_OR;  illegal = 1'b0; end
                    F3_SLT:  begin ctrl = ALU_SLT; illegal = 1'b0; end
                    default: begin ctrl = ALU_ILLEGAL; illegal = 1'b1; end
                endcase
            end
            OP_I: begin
                case (funct3)
                    F3_ADD:  begin ctrl = ALU_ADD; use_imm = 1'b1; illegal = 1'b0; end
                    F3_AND:  begin ctrl = ALU_AND; use_imm = 1'b1; illegal = 1'b0; end
                    F3_OR:   begin ctrl = ALU_OR;  use_imm = 1'b1; illegal = 1'b0; end
                    F3_SLT:  begin ctrl = ALU_SLT; use_imm = 1'b1; illegal = 1'b0; end
                    default: begin ctrl = ALU_ILLEGAL; illegal = 1'b1; end
                endcase
            end
            OP_LOAD, OP_STORE: begin
                ctrl    = ALU_ADD;
                use_imm = 1'b1;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                case (funct3)
                    F3_BEQ:  begin ctrl = ALU_SUB; is_branch = 1'b1; br_on_zero = 1'b1; illegal = 1'b0; end
                    F3_BNE:  begin ctrl = ALU_SUB; is_branch = 1'b1; illegal = 1'b0; end
                    F3_BLT:  begin ctrl = ALU_SLT; is_branch = 1'b1; illegal = 1'b0; end
                    F3_BGE:  begin ctrl = ALU_SGE; is_branch = 1'b1; illegal = 1'b0; end
                    default: begin ctrl = ALU_ILLEGAL; illegal = 1'b1; end
                endcase
            end
            default: begin
                ctrl    = ALU_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes into ALU ctrl, selects operand b, and holds the
// result in a valid/ready register. Optional operand forwarding: ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [4:0]            rs1_idx,
    input  logic [4:0]            rs2_idx,
    input  logic                  fwd_valid,
    input  logic [4:0]            fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_BITS-1:0]  alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  is_branch,
    output logic                  br_on_zero,
    output logic                  illegal
);

    logic [3:0]            w_ctrl;
    logic                  w_use_imm;
    logic                  w_is_branch;
    logic                  w_br_on_zero;
    logic                  w_illegal;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_rs1_val;
    logic [DATA_WIDTH-1:0] w_rs2_val;

    logic                  r_valid;
    logic [CTRL_BITS-1:0]  r_ctrl;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_is_branch;
    logic                  r_br_on_zero;
    logic                  r_illegal;

    alu_ctrl_decode u_decode (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .ctrl       (w_ctrl),
        .use_imm    (w_use_imm),
        .is_branch  (w_is_branch),
        .br_on_zero (w_br_on_zero),
        .illegal    (w_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    // x0 never forwards; it is hardwired to zero in the register file.
    always_comb begin
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_idx)) begin
            w_rs1_val = fwd_data;
        end else begin
            w_rs1_val = rs1_data;
        end
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs2_idx)) begin
            w_rs2_val = fwd_data;
        end else begin
            w_rs2_val = rs2_data;
        end
    end
`else
    assign w_rs1_val = rs1_data;
    assign w_rs2_val = rs2_data;
`endif

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Pipeline register: reset beats flush, flush beats accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_BITS'(ALU_ILLEGAL);
            r_a          <= {DATA_WIDTH{1'b0}};
            r_b          <= {DATA_WIDTH{1'b0}};
            r_is_branch  <= 1'b0;
            r_br_on_zero <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_ctrl       <= CTRL_BITS'(w_ctrl);
            r_a          <= w_rs1_val;
            r_b          <= w_use_imm ? imm : w_rs2_val;
            r_is_branch  <= w_is_branch;
            r_br_on_zero <= w_br_on_zero;
            r_illegal    <= w_illegal;
        end else if (out_ready) begin
            r_valid      <= 1'b0;
        end else begin
            r_valid      <= r_valid;
        end
    end

    assign out_valid  = r_valid;
    assign alu_ctrl   = r_ctrl;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign is_branch  = r_is_branch;
    assign br_on_zero = r_br_on_zero;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized
// run against a behavioural model of the held instruction.
module tb_alu_issue_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7_5;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] imm;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          is_branch;
    logic          br_on_zero;
    logic          illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic [4:0]    rs1_idx = 5'd0;
    logic [4:0]    rs2_idx = 5'd0;
    logic          fwd_valid = 1'b0;
    logic [4:0]    fwd_rd = 5'd0;
    logic [DW-1:0] fwd_data = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.DATA_WIDTH(DW), .CTRL_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
`ifdef ALU_ISSUE_FWD_EN
        .rs1_idx    (rs1_idx),
        .rs2_idx    (rs2_idx),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .is_branch  (is_branch),
        .br_on_zero (br_on_zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [3:0]    ctrl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          br;
        logic          boz;
        logic          ill;
    } held_t;

    // Reference decode written as the instruction-class rules, not a case table.
    function automatic held_t ref_issue(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic [DW-1:0] r1,
                                        input logic [DW-1:0] r2, input logic [DW-1:0] im);
        held_t h;
        logic is_r, is_i, use_im;
        is_r = (op == 7'b0110011);
        is_i = (op == 7'b0010011);
        h.v = 1'b1; h.ctrl = 4'b1111; h.br = 1'b0; h.boz = 1'b0; h.ill = 1'b1;
        use_im = 1'b0;
        if ((is_r || is_i) && f3 == 3'b111) begin
            h.ctrl = 4'b0000; h.ill = 1'b0; use_im = is_i;
        end else if ((is_r || is_i) && f3 == 3'b110) begin
            h.ctrl = 4'b0001; h.ill = 1'b0; use_im = is_i;
        end else if ((is_r || is_i) && f3 == 3'b010) begin
            h.ctrl = 4'b0111; h.ill = 1'b0; use_im = is_i;
        end else if (is_r && f3 == 3'b000) begin
            h.ctrl = f7 ? 4'b0110 : 4'b0010; h.ill = 1'b0;
        end else if ((is_i && f3 == 3'b000) || op == 7'b0000011 || op == 7'b0100011) begin
            h.ctrl = 4'b0010; h.ill = 1'b0; use_im = 1'b1;
        end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
            h.ctrl = 4'b0110; h.ill = 1'b0; h.br = 1'b1; h.boz = (f3 == 3'b000);
        end else if (op == 7'b1100011 && f3 == 3'b100) begin
            h.ctrl = 4'b0111; h.ill = 1'b0; h.br = 1'b1;
        end else if (op == 7'b1100011 && f3 == 3'b101) begin
            h.ctrl = 4'b0101; h.ill = 1'b0; h.br = 1'b1;
        end
        h.a = r1;
        h.b = use_im ? im : r2;
        return h;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                         input logic [DW-1:0] im, input logic ordy, input logic fl);
        in_valid = v; opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_data = r1; rs2_data = r2; imm = im; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd11, 32'd22, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (alu_ctrl !== 4'b1111) begin bad++; $display("FAIL reset_ctrl got=%b exp=1111", alu_ctrl); end
        total++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++; $display("FAIL reset_ab got=%h/%h exp=0/0", alu_a, alu_b); end
        total++; if ({is_branch, br_on_zero, illegal} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {is_branch, br_on_zero, illegal}); end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_r_sub();
        drive(1'b1, 7'b0110011, 3'b000, 1'b1, 32'd75, 32'd25, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sub_valid got=%b exp=1", out_valid); end
        total++; if (alu_ctrl !== 4'b0110) begin bad++; $display("FAIL sub_ctrl got=%b exp=0110", alu_ctrl); end
        total++; if (alu_a !== 32'd75 || alu_b !== 32'd25) begin bad++; $display("FAIL sub_ab got=%0d/%0d exp=75/25", alu_a, alu_b); end
    endtask

    task automatic test_addi();
        drive(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd40, 32'd99, 32'hFFFF_FFB5, 1'b1, 1'b0);
        tick();
        total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("FAIL addi_ctrl got=%b exp=0010", alu_ctrl); end
        total++; if (alu_b !== 32'hFFFF_FFB5 || alu_a !== 32'd40) begin bad++; $display("FAIL addi_ab got=%h/%h exp=00000028/ffffffb5", alu_a, alu_b); end
    endtask

    task automatic test_bge();
        drive(1'b1, 7'b1100011, 3'b101, 1'b0, 32'd5, 32'd3, 32'h0000_0100, 1'b1, 1'b0);
        tick();
        total++; if (alu_ctrl !== 4'b0101) begin bad++; $display("FAIL bge_ctrl got=%b exp=0101", alu_ctrl); end
        total++; if (is_branch !== 1'b1 || br_on_zero !== 1'b0) begin bad++; $display("FAIL bge_flags got=%b%b exp=10", is_branch, br_on_zero); end
        total++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin bad++; $display("FAIL bge_ab got=%0d/%0d exp=5/3", alu_a, alu_b); end
    endtask

    task automatic test_stall();
        drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 7'b0110011, 3'b110, 1'b0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            tick();
            total++;
            if (out_valid !== 1'b1 || alu_ctrl !== 4'b0010 || alu_a !== 32'd1 || alu_b !== 32'd2) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=v%b c%b a%0d b%0d exp=v1 c0010 a1 b2", i, out_valid, alu_ctrl, alu_a, alu_b);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        tick();
        total++;
        if (out_valid !== 1'b1 || alu_ctrl !== 4'b0001 || alu_a !== 32'd10 || alu_b !== 32'd20) begin
            bad++; $display("FAIL stall_next got=v%b c%b a%0d b%0d exp=v1 c0001 a10 b20", out_valid, alu_ctrl, alu_a, alu_b);
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush_illegal();
        drive(1'b1, 7'b0000011, 3'b010, 1'b0, 32'd7, 32'd8, 32'd16, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'b0110011, 3'b111, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        drive(1'b1, 7'b1111111, 3'b000, 1'b0, 32'd9, 32'd9, 32'd9, 1'b1, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'b1111 || is_branch !== 1'b0) begin
            bad++; $display("FAIL illegal got=v%b i%b c%b br%b exp=v1 i1 c1111 br0", out_valid, illegal, alu_ctrl, is_branch);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        held_t      m;
        held_t      cand;
        logic       acc;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0000000;
        m = '{v: 1'b0, ctrl: 4'b0, a: 32'd0, b: 32'd0, br: 1'b0, boz: 1'b0, ill: 1'b0};
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)],
                  3'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            if (c == 0) begin
                ops[5] = 7'b0000000;
            end
            #1;
            total++; if (in_ready !== (!m.v || out_ready)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, (!m.v || out_ready)); end
            acc = in_valid && (!m.v || out_ready);
            cand = ref_issue(opcode, funct3, funct7_5, rs1_data, rs2_data, imm);
            if (flush) m.v = 1'b0;
            else if (acc) m = cand;
            else if (out_ready) m.v = 1'b0;
            tick();
            total++; if (out_valid !== m.v) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m.v); end
            if (m.v) begin
                total++;
                if (alu_ctrl !== m.ctrl || is_branch !== m.br || br_on_zero !== m.boz || illegal !== m.ill) begin
                    bad++; $display("FAIL rnd_decode cyc=%0d got=c%b br%b bz%b i%b exp=c%b br%b bz%b i%b",
                                    c, alu_ctrl, is_branch, br_on_zero, illegal, m.ctrl, m.br, m.boz, m.ill);
                end
                if (!m.ill) begin
                    total++;
                    if (alu_a !== m.a || alu_b !== m.b) begin
                        bad++; $display("FAIL rnd_operands cyc=%0d got=%h/%h exp=%h/%h", c, alu_a, alu_b, m.a, m.b);
                    end
                end
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_sub();
        test_addi();
        test_bge();
        test_stall();
        test_flush_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU.
- Accepts decoded RISC-V instruction fields plus register-file operands and decodes opcode/funct3/funct7 into the ALU's 4-bit ctrl code.
- Selects operand b as register or immediate, then holds the result in a valid/ready pipeline register that drives the ALU's ctrl/a/b inputs.
- Supports stall (backpressure) and flush (branch redirect).

Parameters:
- DATA_WIDTH, 32, operand/immediate width.
- CTRL_BITS, 4, ALU control code width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an instruction this cycle
- in_ready  out  1  stage can accept this cycle
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- rs1_data  in  DATA_WIDTH  register operand 1
- rs2_data  in  DATA_WIDTH  register operand 2
- imm  in  DATA_WIDTH  sign-extended immediate
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  ALU inputs hold a valid instruction
- out_ready  in  1  downstream consumes this cycle
- alu_ctrl  out  CTRL_BITS  to ALU ctrl
- alu_a  out  DATA_WIDTH  to ALU a
- alu_b  out  DATA_WIDTH  to ALU b
- is_branch  out  1  result is used for a branch decision
- br_on_zero  out  1  branch taken when ALU zero=1 (else when zero=0)
- illegal  out  1  held instruction did not decode

Behaviour:
- Reset: out_valid=0, alu_ctrl=4'b1111, alu_a=0, alu_b=0, is_branch=0, br_on_zero=0, illegal=0. Reset overrides flush and handshake.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready; outputs update on that clock edge. Latency is 1 cycle.
- If out_valid && !out_ready: all outputs hold stable, no accept.
- out_valid clears when out_ready && !(in_valid && in_ready).
- Simultaneous consume and accept: the new instruction replaces the old one with no bubble.
- flush: next cycle out_valid=0. An incoming instruction in the same cycle is dropped even if in_valid=1. Flush has priority over accept.
- Decode, R-type (0110011), alu_b=rs2_data:
  - f3=000, f7_5=0 -> ADD 0010
  - f3=000, f7_5=1 -> SUB 0110
  - f3=111 -> AND 0000
  - f3=110 -> OR 0001
  - f3=010 -> SLT 0111
- Decode, I-type (0010011), alu_b=imm:
  - f3=000 -> ADD
  - f3=111 -> AND
  - f3=110 -> OR
  - f3=010 -> SLT
- Decode, load (0000011) and store (0100011): ADD, alu_b=imm.
- Decode, branch (1100011), alu_b=rs2_data, is_branch=1:
  - f3=000 BEQ -> SUB, br_on_zero=1
  - f3=001 BNE -> SUB, br_on_zero=0
  - f3=100 BLT -> SLT, br_on_zero=0
  - f3=101 BGE -> SGE 0101, br_on_zero=0
- alu_a = rs1_data for all legal instructions.
- Any other opcode/funct combination: alu_ctrl=4'b1111 (ALU default, result 0), illegal=1, is_branch=0. The instruction still flows with out_valid=1.
- No arithmetic in this block. Widths pass through unchanged.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- When defined, extra ports are added:
  - rs1_idx in 5, rs2_idx in 5
  - fwd_valid in 1, fwd_rd in 5, fwd_data in DATA_WIDTH
- At accept, if fwd_valid && fwd_rd!=0 && fwd_rd==rs1_idx, alu_a=fwd_data. Same rule for rs2_idx and the register-sourced alu_b.
- The immediate path is never forwarded.
- When not defined: ports absent, operands taken directly from rs*_data.

Decomposition:
- Shared package alu_pkg holds:
  - ALU ctrl localparams: AND, OR, ADD, SUB, SLT, SGE, NOR, ILLEGAL=4'b1111
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
- One combinational sub-module alu_ctrl_decode (opcode, funct3, funct7_5 -> ctrl, use_imm, is_branch, br_on_zero, illegal).
- Pipeline register and handshake live in the top.

Test Plan:
- Reset held 2 cycles with in_valid=1 -> out_valid=0, alu_ctrl=1111, in_ready=1 after release.
- R-type SUB (0110011, f3=000, f7_5=1), rs1=75, rs2=25, out_ready=1 -> next cycle alu_ctrl=0110, a=75, b=25, out_valid=1.
- ADDI with imm=-75 (32'hFFFFFFB5), rs2=99 -> alu_ctrl=0010, alu_b=FFFFFFB5.
- BGE, rs1=5, rs2=3 -> alu_ctrl=0101, is_branch=1, br_on_zero=0.
- Stall: out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs frozen. Release -> next instruction appears 1 cycle later, none lost or duplicated.
- flush with in_valid=1 same cycle -> out_valid=0 next cycle. Opcode 1111111 -> illegal=1, alu_ctrl=1111.
